reg_file_bank: RTL



---
 rtl/legv8_pkg.sv | 19 +
 rtl/reg_word_en_r.sv | 40 ++++
 rtl/reg_file_bank.sv | 93 +++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// ============================================================================
// Module : legv8_pkg
// Brief  : Shared LEGv8 register-file sizes and word/address types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_pkg;

    localparam int WORD_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_IDX = 31;

    typedef logic [WORD_W-1:0]           word_t;
    typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

endpackage : legv8_pkg

`default_nettype wire

// File: rtl/reg_word_en_r.sv
// ============================================================================
// Module : reg_word_en_r
// Brief  : WIDTH-bit register with write enable and synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_word_en_r #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wren,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (wren) begin
            word_d = D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign Q = word_q;

endmodule : reg_word_en_r

`default_nettype wire

// File: rtl/reg_file_bank.sv
// ============================================================================
// Module : reg_file_bank
// Brief  : 1W/2R register bank with optional zero register. Define
//          REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_bank
    import legv8_pkg::*;
#(
    parameter int  WIDTH    = WORD_W,
    parameter int  DEPTH    = NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);

    localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_ZERO_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] w_word [DEPTH];
    logic             w_wr_legal;
    logic [WIDTH-1:0] w_rd_data_a;
    logic [WIDTH-1:0] w_rd_data_b;

    // An index is backed by storage only if in range and not the zero register.
    function automatic logic addr_legal(input logic [AW-1:0] addr);
        return ({1'b0, addr} < C_DEPTH) && !(ZERO_REG && (addr == C_ZERO_IDX));
    endfunction

    assign w_wr_legal = wr_en && !reset && addr_legal(wr_addr);

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG && (i == DEPTH - 1)) begin : g_zero
            assign w_word[i] = '0;
        end else begin : g_reg
            localparam logic [AW-1:0] C_IDX = AW'(i);
            logic w_wren;

            assign w_wren = w_wr_legal && (wr_addr == C_IDX);

            reg_word_en_r #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk   (clk),
                .reset (reset),
                .wren  (w_wren),
                .D     (wr_data),
                .Q     (w_word[i])
            );
        end
    end

    always_comb begin
        w_rd_data_a = '0;
        if (addr_legal(rd_addr_a)) begin
            w_rd_data_a = w_word[rd_addr_a];
        end
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_legal && (rd_addr_a == wr_addr)) begin
            w_rd_data_a = wr_data;
        end
`endif
    end

    always_comb begin
        w_rd_data_b = '0;
        if (addr_legal(rd_addr_b)) begin
            w_rd_data_b = w_word[rd_addr_b];
        end
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_legal && (rd_addr_b == wr_addr)) begin
            w_rd_data_b = wr_data;
        end
`endif
    end

    assign rd_data_a = w_rd_data_a;
    assign rd_data_b = w_rd_data_b;

endmodule : reg_file_bank

`default_nettype wire
